// File: rtl/pmp_check_seq.sv
// Serial PMP permission checker: walks the entry table one entry per cycle through a
// single shared matcher. Define PMP_NAPOT_EN to compile in NA4/NAPOT matching.
module pmp_check_seq #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [8*NUM_ENTRIES-1:0]  pmp_cfg,
  input  logic [32*NUM_ENTRIES-1:0] pmp_addr,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [1:0]                req_size,
  input  logic [1:0]                req_type,
  input  logic                      req_priv_m,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_allow,
  output logic                      resp_hit,
  output logic [IDX_W-1:0]          resp_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [32:0]      last_q;
  logic [1:0]       type_q;
  logic             priv_q;
  logic [IDX_W-1:0] idx_q;

  logic [7:0]  cfg_arr [NUM_ENTRIES];
  logic [31:0] pa_arr  [NUM_ENTRIES];
  logic [7:0]  cur_cfg;
  logic [31:0] cur_addr;
  logic [31:0] lo_addr;
  logic [1:0]  bytes_m1;
  logic        match;
  logic        hit_allow;
  logic        unused_cfg_bits;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_arr[i] = pmp_cfg[8*i +: 8];
      pa_arr[i]  = pmp_addr[32*i +: 32];
    end
  end

  // Entry 0 has no predecessor, so its TOR window starts at address 0.
  assign cur_cfg  = cfg_arr[idx_q];
  assign cur_addr = pa_arr[idx_q];
  assign lo_addr  = (idx_q == '0) ? 32'd0 : pa_arr[idx_q - IDX_W'(1)];
  assign unused_cfg_bits = ^cur_cfg[6:5];

  always_comb begin
    case (req_size)
      2'b00:   bytes_m1 = 2'd0;
      2'b01:   bytes_m1 = 2'd1;
      default: bytes_m1 = 2'd3;
    endcase
  end

`ifdef PMP_NAPOT_EN
  logic [31:0] napot_mask;
  assign napot_mask = cur_addr ^ (cur_addr + 32'd1);
`endif

  // NOTE: every path assigns match after the default, so no latch is inferred.
  always_comb begin
    match = 1'b0;
    if (!last_q[32]) begin
      case (cur_cfg[4:3])
        2'b01: match = (addr_q >= lo_addr) && (last_q[31:0] < cur_addr);
`ifdef PMP_NAPOT_EN
        2'b10: match = (addr_q[31:2] == cur_addr[31:2]) &&
                       (last_q[31:2] == cur_addr[31:2]);
        2'b11: match = (((addr_q ^ cur_addr) & ~napot_mask) == 32'd0) &&
                       (((last_q[31:0] ^ cur_addr) & ~napot_mask) == 32'd0);
`endif
        default: match = 1'b0;
      endcase
    end
  end

  // Unlocked entries never restrict M-mode; type_q is 0..2 here and selects R/W/X.
  assign hit_allow = (priv_q && !cur_cfg[7]) || cur_cfg[type_q];

  assign req_ready = (state_q == IDLE);

  // NOTE: the request datapath registers are left out of reset; they are always
  // loaded on acceptance before anything reads them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      resp_valid <= 1'b0;
      resp_allow <= 1'b0;
      resp_hit   <= 1'b0;
      resp_idx   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            last_q <= {1'b0, req_addr} + {31'd0, bytes_m1};
            type_q <= req_type;
            priv_q <= req_priv_m;
            idx_q  <= '0;
            if (req_type == 2'b11) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_allow <= 1'b0;
              resp_hit   <= 1'b0;
              resp_idx   <= '0;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          if (match) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_allow <= hit_allow;
            resp_hit   <= 1'b1;
            resp_idx   <= idx_q;
          end else if (idx_q == LAST_IDX) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_allow <= priv_q;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_check_seq.sv
// Self-checking bench for pmp_check_seq: directed scenarios plus randomized requests
// checked against a range-based reference model of the PMP rules.
module tb_pmp_check_seq;

  localparam int NUM_ENTRIES = 16;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
`ifdef PMP_NAPOT_EN
  localparam bit NAPOT_EN = 1'b1;
`else
  localparam bit NAPOT_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [8*NUM_ENTRIES-1:0]  pmp_cfg;
  logic [32*NUM_ENTRIES-1:0] pmp_addr;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [31:0]               req_addr = '0;
  logic [1:0]                req_size = '0;
  logic [1:0]                req_type = '0;
  logic                      req_priv_m = 1'b0;
  logic                      resp_valid;
  logic                      resp_ready = 1'b0;
  logic                      resp_allow;
  logic                      resp_hit;
  logic [IDX_W-1:0]          resp_idx;

  logic [7:0]  cfg_t  [NUM_ENTRIES];
  logic [31:0] addr_t [NUM_ENTRIES];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      pmp_cfg[8*i +: 8]   = cfg_t[i];
      pmp_addr[32*i +: 32] = addr_t[i];
    end
  end

  pmp_check_seq #(.NUM_ENTRIES(NUM_ENTRIES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pmp_cfg    (pmp_cfg),
    .pmp_addr   (pmp_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_type   (req_type),
    .req_priv_m (req_priv_m),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_allow (resp_allow),
    .resp_hit   (resp_hit),
    .resp_idx   (resp_idx)
  );

  // Reference model: each entry describes a byte range; the access [first, last]
  // matches when it lies wholly inside that range. Lowest index wins.
  task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                       input logic pm, output logic allow, output logic hit,
                       output logic [IDX_W-1:0] idx, output int k);
    logic [63:0] first, last, base, span;
    int nbytes, t;
    bit matched;
    allow = 1'b0; hit = 1'b0; idx = '0; k = NUM_ENTRIES;
    if (ty == 2'b11) begin
      k = 0;
      return;
    end
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    first  = {32'd0, a};
    last   = first + 64'(nbytes) - 64'd1;
    if (last <= 64'hFFFF_FFFF) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        matched = 1'b0;
        base = 64'd0; span = 64'd0;
        case (cfg_t[i][4:3])
          2'b01: begin
            base = (i == 0) ? 64'd0 : {32'd0, addr_t[i-1]};
            span = ({32'd0, addr_t[i]} > base) ? ({32'd0, addr_t[i]} - base) : 64'd0;
          end
          2'b10: if (NAPOT_EN) begin
            base = {32'd0, addr_t[i] & 32'hFFFF_FFFC};
            span = 64'd4;
          end
          2'b11: if (NAPOT_EN) begin
            t = 0;
            while (t < 32 && addr_t[i][t]) t++;
            span = 64'd1 << (t + 1);
            base = {32'd0, addr_t[i]} & ~(span - 64'd1);
          end
          default: ;
        endcase
        if (span != 64'd0 && first >= base && last < base + span) matched = 1'b1;
        if (matched) begin
          hit = 1'b1;
          idx = IDX_W'(i);
          k   = i + 1;
          break;
        end
      end
    end
    if (!hit) allow = pm;
    else if (pm && !cfg_t[idx][7]) allow = 1'b1;
    else case (ty)
      2'b00:   allow = cfg_t[idx][0];
      2'b01:   allow = cfg_t[idx][1];
      default: allow = cfg_t[idx][2];
    endcase
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_t[i]  = 8'h00;
      addr_t[i] = 32'h0;
    end
  endtask

  task automatic run_req(input string name, input logic [31:0] a, input logic [1:0] sz,
                         input logic [1:0] ty, input logic pm, input int stall);
    logic e_allow, e_hit;
    logic [IDX_W-1:0] e_idx;
    logic [IDX_W+1:0] exp_v;
    int e_k, cyc;
    model(a, sz, ty, pm, e_allow, e_hit, e_idx, e_k);
    exp_v = {e_allow, e_hit, e_idx};
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_addr = a; req_size = sz; req_type = ty; req_priv_m = pm;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (resp_valid !== 1'b1 && cyc < 64);
    checks++;
    if (cyc != e_k + 1) begin
      errors++; $display("FAIL %s latency: got %0d want %0d cycles", name, cyc, e_k + 1);
    end
    checks++;
    if ({req_ready, resp_allow, resp_hit, resp_idx} !== {1'b0, exp_v}) begin
      errors++;
      $display("FAIL %s response: got ready=%b allow=%b hit=%b idx=%0d want ready=0 allow=%b hit=%b idx=%0d",
               name, req_ready, resp_allow, resp_hit, resp_idx, e_allow, e_hit, e_idx);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_allow, resp_hit, resp_idx} !== {2'b10, exp_v}) begin
        errors++;
        $display("FAIL %s stall %0d: got valid=%b ready=%b allow=%b hit=%b idx=%0d want valid=1 ready=0 allow=%b hit=%b idx=%0d",
                 name, s, resp_valid, req_ready, resp_allow, resp_hit, resp_idx, e_allow, e_hit, e_idx);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s after handshake: got valid=%b ready=%b want valid=0 ready=1",
               name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_allow, resp_hit, resp_idx} !== {3'b100, 1'b0, {IDX_W{1'b0}}}) begin
      errors++;
      $display("FAIL reset state: got ready=%b valid=%b allow=%b hit=%b idx=%0d want 1 0 0 0 0",
               req_ready, resp_valid, resp_allow, resp_hit, resp_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tor_basic();
    clear_cfg();
    cfg_t[0] = 8'h09; addr_t[0] = 32'h0000_1000;
    run_req("tor_hit_u_read", 32'h0000_0FFC, 2'b10, 2'b00, 1'b0, 0);
    run_req("tor_straddle_u", 32'h0000_0FFE, 2'b10, 2'b00, 1'b0, 0);
    run_req("tor_straddle_m", 32'h0000_0FFE, 2'b10, 2'b00, 1'b1, 0);
    run_req("tor_write_denied", 32'h0000_0000, 2'b00, 2'b01, 1'b0, 0);
  endtask

  task automatic test_napot_priority();
    clear_cfg();
    cfg_t[2] = 8'h19; addr_t[2] = 32'h2000_01FF;
    addr_t[4] = 32'h2000_0000;
    cfg_t[5] = 8'h0B; addr_t[5] = 32'h2000_0400;
    run_req("napot_priority_write", 32'h2000_0100, 2'b10, 2'b01, 1'b0, 0);
    run_req("napot_priority_read", 32'h2000_03FC, 2'b10, 2'b00, 1'b0, 0);
    cfg_t[7] = 8'h14; addr_t[7] = 32'h3000_0008;
    run_req("na4_exec", 32'h3000_000A, 2'b01, 2'b10, 1'b0, 0);
  endtask

  task automatic test_wrap();
    clear_cfg();
    cfg_t[0] = 8'h0F; addr_t[0] = 32'hFFFF_FFFF;
    cfg_t[3] = 8'h1F; addr_t[3] = 32'hFFFF_FFFF;
    run_req("wrap_half_u", 32'hFFFF_FFFF, 2'b01, 2'b00, 1'b0, 0);
    run_req("top_word_u", 32'hFFFF_FFFC, 2'b11, 2'b00, 1'b0, 0);
    run_req("below_top_u", 32'hFFFF_FFF0, 2'b10, 2'b00, 1'b0, 0);
  endtask

  task automatic test_lock();
    clear_cfg();
    addr_t[0] = 32'h0000_0100;
    cfg_t[1] = 8'h08; addr_t[1] = 32'h0000_0200;
    run_req("unlocked_m_exec", 32'h0000_0180, 2'b10, 2'b10, 1'b1, 0);
    cfg_t[1] = 8'h88;
    run_req("locked_m_exec", 32'h0000_0180, 2'b10, 2'b10, 1'b1, 0);
    run_req("locked_u_exec", 32'h0000_0180, 2'b10, 2'b10, 1'b0, 0);
  endtask

  task automatic test_type_deny();
    clear_cfg();
    cfg_t[0] = 8'h0F; addr_t[0] = 32'h0001_0000;
    run_req("type11_m", 32'h0000_0040, 2'b10, 2'b11, 1'b1, 0);
  endtask

  task automatic test_stall();
    clear_cfg();
    cfg_t[3] = 8'h0A; addr_t[3] = 32'h0000_8000;
    run_req("stall_hit", 32'h0000_0400, 2'b00, 2'b01, 1'b0, 5);
    run_req("stall_miss", 32'h0000_9000, 2'b00, 2'b01, 1'b0, 5);
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    clear_cfg();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_type = 2'b00; req_priv_m = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL mid_scan_reset: got ready=%b valid=%b want ready=1 valid=0", req_ready, resp_valid);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (NUM_ENTRIES + 4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL mid_scan_dropped: got a response want none");
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 200; n++) begin
      if (n % 10 == 0) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          cfg_t[i]  = 8'($urandom);
          addr_t[i] = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 'h1000));
        end
      end
      case ($urandom_range(0, 7))
        0:       a = $urandom();
        1:       a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: a = 32'($urandom_range(0, 'h1000));
      endcase
      run_req("random", a, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  initial begin
    clear_cfg();
    test_reset();
    test_tor_basic();
    test_napot_priority();
    test_wrap();
    test_lock();
    test_type_deny();
    test_stall();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
